// File: rtl/seg7_if.sv
// Digit-write, commit and display-drive signals of the seg7_scan display driver.
// The master side is the upstream digit producer. The slave side is the scan driver.
interface seg7_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [3:0]            wr_data;
  logic                  commit;
  logic                  blank_lz;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  pending;
  logic                  frame_tick;

  modport master (
    output wr_en, wr_addr, wr_data, commit, blank_lz,
    input  seg, an, pending, frame_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, blank_lz,
    output seg, an, pending, frame_tick
  );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment driver with double-buffered digit registers.
// A commit copies shadow to disp only at a frame boundary, so digits never tear.
module seg7_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  seg7_if.slave  bus
);
  localparam int                  AW         = $clog2(NUM_DIGITS);
  localparam int                  PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [AW-1:0]       IDX_LAST   = AW'(NUM_DIGITS - 1);
  localparam logic [6:0]          SEG_RESET  = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
  localparam logic [NUM_DIGITS-1:0] AN_RESET = ~NUM_DIGITS'(1);

  typedef logic [3:0] digit_t;

  function automatic logic [6:0] decode(input digit_t d);
    case (d)
      4'h0:    decode = 7'h3F;
      4'h1:    decode = 7'h06;
      4'h2:    decode = 7'h5B;
      4'h3:    decode = 7'h4F;
      4'h4:    decode = 7'h66;
      4'h5:    decode = 7'h6D;
      4'h6:    decode = 7'h7D;
      4'h7:    decode = 7'h07;
      4'h8:    decode = 7'h7F;
      4'h9:    decode = 7'h6F;
      4'hA:    decode = 7'h77;
      4'hB:    decode = 7'h7C;
      4'hC:    decode = 7'h39;
      4'hD:    decode = 7'h5E;
      4'hE:    decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  tick_q;
  digit_t                shadow_q [NUM_DIGITS];
  digit_t                disp_q   [NUM_DIGITS];
  digit_t                disp_d   [NUM_DIGITS];
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic slot_adv, wrap, copy;

  assign slot_adv = (presc_q == PRESC_LAST);
  assign wrap     = slot_adv && (idx_q == IDX_LAST);
  // A commit on the wrap edge itself is folded into that edge's copy.
  assign copy     = wrap && (pending_q || bus.commit);

  // Next-state logic: counters, pending flag and the post-edge disp image.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    presc_d   = slot_adv ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    pending_d = pending_q;
    if (wrap)          idx_d = '0;
    else if (slot_adv) idx_d = idx_q + 1'b1;
    if (copy)             pending_d = 1'b0;
    else if (bus.commit)  pending_d = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      disp_d[i] = copy ? shadow_q[i] : disp_q[i];
    end
  end

  // Display drive for the slot being entered, using the post-edge disp image.
  always_comb begin
    logic       nz_above;
    logic       blank;
    digit_t     cur;
    logic [6:0] val;
    nz_above = 1'b0;
    cur      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (AW'(i) == idx_d) cur = disp_d[i];
      if (i >= int'(idx_d) && disp_d[i] != 4'h0) nz_above = 1'b1;
    end
    blank = bus.blank_lz && (idx_d != '0) && !nz_above;
    val   = blank ? 7'h00 : decode(cur);
    seg_d = SEG_ACTIVE_LOW ? ~val : val;
    an_d  = ~(NUM_DIGITS'(1) << idx_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      seg_q     <= SEG_RESET;
      an_q      <= AN_RESET;
      // NOTE: both digit files are small flop arrays and must read as zero after
      // reset, so they are reset here rather than left to RAM inference.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      tick_q    <= wrap;
      disp_q    <= disp_d;
      // Out-of-range addresses match no slot and are dropped.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.wr_en && bus.wr_addr == AW'(i)) shadow_q[i] <= bus.wr_data;
      end
      if (slot_adv) begin
        seg_q <= seg_d;
        an_q  <= an_d;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.pending    = pending_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: two instances (4 digits / prescale 4 and
// 3 digits / prescale 3) share one stimulus stream and are compared to a time-based model.
module tb_seg7_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_if #(.NUM_DIGITS(4)) bus0 ();
  seg7_if #(.NUM_DIGITS(3)) bus1 ();

  seg7_scan #(.NUM_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  seg7_scan #(.NUM_DIGITS(3), .PRESCALE(3), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the scan is derived from the edge count alone.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         m_n [2] = '{4, 3};
  int         m_p [2] = '{4, 3};
  int         m_e [2];
  logic [3:0] m_sh [2][8];
  logic [3:0] m_dp [2][8];
  bit         m_pend [2];
  bit         m_blz [2];
  bit         blz_lvl = 1'b0;

  function automatic int exp_idx(input int k);
    return (m_e[k] / m_p[k]) % m_n[k];
  endfunction

  function automatic logic [31:0] exp_seg(input int k);
    int         idx;
    bit         nz;
    logic [6:0] v;
    idx = exp_idx(k);
    nz  = 1'b0;
    for (int j = idx; j < m_n[k]; j++) if (m_dp[k][j] != 4'h0) nz = 1'b1;
    if (m_blz[k] && idx != 0 && !nz) v = 7'h00;
    else                            v = seg_tab[m_dp[k][idx]];
    return {25'd0, ~v};
  endfunction

  function automatic logic [31:0] exp_an(input int k);
    logic [31:0] mask;
    mask = (32'd1 << m_n[k]) - 32'd1;
    return ~(32'd1 << exp_idx(k)) & mask;
  endfunction

  function automatic logic [31:0] exp_tick(input int k);
    return {31'd0, (m_e[k] > 0) && (m_e[k] % (m_n[k] * m_p[k]) == 0)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_e[k]    = 0;
      m_pend[k] = 1'b0;
      m_blz[k]  = 1'b0;
      for (int j = 0; j < 8; j++) begin
        m_sh[k][j] = 4'h0;
        m_dp[k][j] = 4'h0;
      end
    end
  endtask

  task automatic model_step(input bit we, input logic [1:0] a, input logic [3:0] d,
                            input bit cm, input bit blz);
    for (int k = 0; k < 2; k++) begin
      bit wrap_e;
      m_e[k]++;
      wrap_e = (m_e[k] % (m_n[k] * m_p[k]) == 0);
      if (wrap_e && (m_pend[k] || cm)) begin
        for (int j = 0; j < 8; j++) m_dp[k][j] = m_sh[k][j];
        m_pend[k] = 1'b0;
      end else if (cm) begin
        m_pend[k] = 1'b1;
      end
      if (we && int'(a) < m_n[k]) m_sh[k][a] = d;
      if (m_e[k] % m_p[k] == 0) m_blz[k] = blz;
    end
  endtask

  task automatic check_outputs();
    check("seg0",  {25'd0, bus0.seg},        exp_seg(0));
    check("an0",   {28'd0, bus0.an},         exp_an(0));
    check("pend0", {31'd0, bus0.pending},    {31'd0, m_pend[0]});
    check("tick0", {31'd0, bus0.frame_tick}, exp_tick(0));
    check("seg1",  {25'd0, bus1.seg},        exp_seg(1));
    check("an1",   {29'd0, bus1.an},         exp_an(1));
    check("pend1", {31'd0, bus1.pending},    {31'd0, m_pend[1]});
    check("tick1", {31'd0, bus1.frame_tick}, exp_tick(1));
  endtask

  task automatic drive(input bit we, input logic [1:0] a, input logic [3:0] d,
                       input bit cm, input bit blz);
    bus0.wr_en = we;  bus0.wr_addr = a;  bus0.wr_data = d;  bus0.commit = cm;  bus0.blank_lz = blz;
    bus1.wr_en = we;  bus1.wr_addr = a;  bus1.wr_data = d;  bus1.commit = cm;  bus1.blank_lz = blz;
  endtask

  // One clock: check state left by the last edge, then present inputs for the next.
  task automatic cycle(input bit we, input logic [1:0] a, input logic [3:0] d, input bit cm);
    @(negedge clk);
    check_outputs();
    drive(we, a, d, cm, blz_lvl);
    model_step(we, a, d, cm, blz_lvl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 4'h0, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 1'b0, blz_lvl);
    model_step(1'b0, 2'd0, 4'h0, 1'b0, blz_lvl);
  endtask

  initial begin
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    release_reset();

    // Plain scan: all digits read 0, ticks once per frame.
    idle(40);

    // Atomic update: {3,2,1,0} then a mid-frame commit.
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 4'(i), 1'b0);
    idle(3);
    cycle(1'b0, 2'd0, 4'h0, 1'b1);
    idle(40);

    // Commit and write to slot 0 on the wrap edge of the 4-digit instance.
    for (int g = 0; g < 20 && ((m_e[0] + 1) % 16 != 0); g++) idle(1);
    check("wrap_align", 32'((m_e[0] + 1) % 16), 32'd0);
    cycle(1'b1, 2'd0, 4'h8, 1'b1);
    idle(24);
    cycle(1'b0, 2'd0, 4'h0, 1'b1);
    idle(40);

    // Leading-zero blanking: {0,0,0,5}, then all zero.
    blz_lvl = 1'b1;
    cycle(1'b1, 2'd0, 4'h5, 1'b0);
    for (int i = 1; i < 4; i++) cycle(1'b1, 2'(i), 4'h0, 1'b0);
    cycle(1'b0, 2'd0, 4'h0, 1'b1);
    idle(40);
    cycle(1'b1, 2'd0, 4'h0, 1'b1);
    idle(40);

    // Decode sweep through slot 0, with a write to address 3 mixed in.
    blz_lvl = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cycle(1'b1, 2'd0, 4'(c), 1'b1);
      cycle(1'b1, 2'd3, 4'(15 - c), 1'b0);
      idle(24);
    end

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) blz_lvl = ~blz_lvl;
      cycle($urandom_range(0, 3) == 0, 2'($urandom), 4'($urandom), $urandom_range(0, 19) == 0);
    end

    // Reset while a commit is pending and the 4-digit scan sits on index 2.
    blz_lvl = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 4'h9, 1'b0);
    for (int g = 0; g < 20 && (m_e[0] % 16 != 1); g++) idle(1);
    cycle(1'b0, 2'd0, 4'h0, 1'b1);
    for (int g = 0; g < 20 && exp_idx(0) != 2; g++) idle(1);
    check("pre_rst_idx", 32'(exp_idx(0)), 32'd2);
    check("pre_rst_pend", {31'd0, bus0.pending}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    release_reset();
    idle(40);
    cycle(1'b0, 2'd0, 4'h0, 1'b1);
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
